// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// pong_game_ctrl : Pong match sequencer (serve pacing, scoring, winner).
// Revision 1.0
// ============================================================================
module pong_game_ctrl #(
    parameter int WIN_SCORE   = 10,
    parameter int SERVE_TICKS = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic       miss_p1,
    input  logic       miss_p2,
    output logic [1:0] state,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       run,
    output logic       serve,
    output logic       serve_dir,
    output logic       winner
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(SERVE_TICKS - 1);
    localparam logic [3:0]       c_WIN    = 4'(WIN_SCORE);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]       r_p1, r_p2, w_p1_nxt, w_p2_nxt;
    logic [3:0]       w_p1_inc, w_p2_inc;
    logic             r_serve, w_serve_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_win, w_win_nxt;

    assign w_p1_inc = r_p1 + 4'd1;
    assign w_p2_inc = r_p2 + 4'd1;

    // Abort (start low) outranks misses, which outrank ticks.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_p1_nxt    = r_p1;
        w_p2_nxt    = r_p2;
        w_serve_nxt = 1'b0;
        w_dir_nxt   = r_dir;
        w_win_nxt   = r_win;
        case (r_state)
            QI: begin
                if (start) begin
                    w_p1_nxt    = 4'd0;
                    w_p2_nxt    = 4'd0;
                    w_dir_nxt   = 1'b1;
                    w_cnt_nxt   = c_RELOAD;
                    w_state_nxt = QGAME_1;
                end
            end
            QGAME_1: begin
                if (!start) begin
                    w_state_nxt = QI;
                end else if (tick) begin
                    if (r_cnt == '0) begin
                        w_serve_nxt = 1'b1;
                        w_state_nxt = QGAME_2;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            QGAME_2: begin
                if (!start) begin
                    w_state_nxt = QI;
                end else if (miss_p1 && miss_p2) begin
                    w_cnt_nxt   = c_RELOAD;
                    w_state_nxt = QGAME_1;
                end else if (miss_p1) begin
                    w_p2_nxt  = w_p2_inc;
                    w_dir_nxt = 1'b0;
                    if (w_p2_inc == c_WIN) begin
                        w_win_nxt   = 1'b1;
                        w_state_nxt = QDONE;
                    end else begin
                        w_cnt_nxt   = c_RELOAD;
                        w_state_nxt = QGAME_1;
                    end
                end else if (miss_p2) begin
                    w_p1_nxt  = w_p1_inc;
                    w_dir_nxt = 1'b1;
                    if (w_p1_inc == c_WIN) begin
                        w_win_nxt   = 1'b0;
                        w_state_nxt = QDONE;
                    end else begin
                        w_cnt_nxt   = c_RELOAD;
                        w_state_nxt = QGAME_1;
                    end
                end
            end
            QDONE: begin
                if (!start) begin
                    w_state_nxt = QI;
                end
            end
            default: w_state_nxt = QI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= QI;
            r_cnt   <= '0;
            r_p1    <= 4'd0;
            r_p2    <= 4'd0;
            r_serve <= 1'b0;
            r_dir   <= 1'b1;
            r_win   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_p1    <= w_p1_nxt;
            r_p2    <= w_p2_nxt;
            r_serve <= w_serve_nxt;
            r_dir   <= w_dir_nxt;
            r_win   <= w_win_nxt;
        end
    end

    assign state     = r_state;
    assign p1_score  = r_p1;
    assign p2_score  = r_p2;
    assign run       = (r_state == QGAME_2);
    assign serve     = r_serve;
    assign serve_dir = r_dir;
    assign winner    = r_win;

endmodule
`default_nettype wire
